hazard_forwarding_unit: RTL

//  Decode-stage hazard controller for the 5-stage RV32I pipeline. Keeps a shadow copy of the

---
 rtl/hazard_forwarding_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/hazard_forwarding_unit.sv
// Decode-stage hazard controller: tracks rd/we/load of the EX, MEM and WB instructions,
// raises load-use stalls, selects ID operand forwarding and counts stalls/flushes.
module hazard_forwarding_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_rf_enable,
  input  logic             id_load_instr,
  input  logic             flush,
  output logic             cu_mux_sel,
  output logic             pc_load_en,
  output logic             if_id_load_en,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_we, ex_ld, mem_we, wb_we;
  logic       stall, bubble;

  function automatic logic hit(input logic we, input logic [4:0] rd,
                               input logic [4:0] rs, input logic uses);
    return we && (rd == rs) && (rs != 5'd0) && uses;
  endfunction

  // Youngest producer wins: EX, then MEM, then WB, else the register file.
  function automatic logic [1:0] fwd_select(input logic [4:0] rs, input logic uses,
                                            input logic [4:0] e_rd, input logic e_we,
                                            input logic [4:0] m_rd, input logic m_we,
                                            input logic [4:0] w_rd, input logic w_we);
    if (hit(e_we, e_rd, rs, uses))      return 2'b01;
    else if (hit(m_we, m_rd, rs, uses)) return 2'b10;
    else if (hit(w_we, w_rd, rs, uses)) return 2'b11;
    else                                return 2'b00;
  endfunction

  always_comb begin
    stall         = 1'b0;
    cu_mux_sel    = 1'b1;
    pc_load_en    = 1'b0;
    if_id_load_en = 1'b0;
    fwd_sel_a     = 2'b00;
    fwd_sel_b     = 2'b00;
    if (!reset) begin
      stall = ex_ld && !flush &&
              (hit(ex_we, ex_rd, id_rs1, id_uses_rs1) ||
               hit(ex_we, ex_rd, id_rs2, id_uses_rs2));
      cu_mux_sel    = stall || flush;
      pc_load_en    = !stall;
      if_id_load_en = !stall;
      fwd_sel_a = fwd_select(id_rs1, id_uses_rs1, ex_rd, ex_we, mem_rd, mem_we, wb_rd, wb_we);
      fwd_sel_b = fwd_select(id_rs2, id_uses_rs2, ex_rd, ex_we, mem_rd, mem_we, wb_rd, wb_we);
    end
    bubble = stall || flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd  <= 5'd0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_rd <= 5'd0;
      mem_we <= 1'b0;
      wb_rd  <= 5'd0;
      wb_we  <= 1'b0;
    end else begin
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      if (bubble) begin
        ex_rd <= 5'd0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
      end else begin
        ex_rd <= id_rd;
        ex_we <= id_rf_enable;
        ex_ld <= id_load_instr;
      end
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
